// File: rtl/dsp_target.sv
// -----------------------------------------------------------------------------
// dsp_target
//
// Bus responder for the shared FRAME_B/CMD/IRDY_B/TRDY_B/AD bus used by the
// DSP initiator models. It decodes the address phase and inserts WAIT_STATES
// wait cycles. It then completes one single-word read or write against a
// local register file of 2**AW 32-bit words. Several instances with distinct
// BASE_ADDR can share one bus. All lines are pulled up, so a released line
// reads as 1.
//
// Parameters:
//   BASE_ADDR    decode base, aligned to 2**AW
//   AW           word-address bits (storage depth is 2**AW)
//   WAIT_STATES  wait cycles before TRDY_B may fall (0..15)
//
// Ports:
//   CLK      in     bus clock, rising-edge sampling
//   RST      in     asynchronous active-high reset (also clears storage)
//   FRAME_B  in     low while a transaction is in progress
//   CMD      in     sampled with the address: 0 = read, 1 = write
//   IRDY_B   in     initiator ready, active low
//   TRDY_B   out    target ready, active low, released (z) when not in a hit
//   AD       inout  multiplexed address/data, driven only during a read ACK
// -----------------------------------------------------------------------------
module dsp_target #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
   parameter int          AW          = 4,
   parameter int          WAIT_STATES = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        FRAME_B,
   input  logic        CMD,
   input  logic        IRDY_B,
   output wire         TRDY_B,
   inout  wire  [31:0] AD
);

   localparam int DEPTH = 1 << AW;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DATA = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;
   localparam logic [1:0] TURN = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          cmd_q, cmd_d;
   logic [31:0]   ad_out_q, ad_out_d;
   logic [31:0]   mem_q [DEPTH];

   logic          hit;
   logic          wr_en;
   logic          trdy_oe;
   logic          ad_oe;

   // Only the upper address bits take part in the decode. The low AW bits
   // select the word inside this target.
   assign hit = (AD[31:AW] == BASE_ADDR[31:AW]);

   // TRDY_B is held high through the wait states and pulled low for the
   // single ACK cycle. Read data is driven on AD only in that same cycle.
   assign trdy_oe = (state_q == DATA) || (state_q == ACK);
   assign ad_oe   = (state_q == ACK) && !cmd_q;
   assign TRDY_B  = trdy_oe ? (state_q != ACK) : 1'bz;
   assign AD      = ad_oe ? ad_out_q : 32'hz;

   // Next-state logic for the transaction FSM.
   // A released FRAME_B in DATA takes priority over everything else. This
   // lets an abort win even when IRDY_B is low on the same edge.
   // TURN waits for FRAME_B to go high, so a stale low FRAME_B is never
   // decoded a second time.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      cmd_d    = cmd_q;
      ad_out_d = ad_out_q;
      wr_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!FRAME_B) begin
               idx_d = AD[AW-1:0];
               cmd_d = CMD;
               if (hit) begin
                  state_d = DATA;
                  cnt_d   = WAIT_INIT;
               end else begin
                  state_d = TURN;
               end
            end
         end
         DATA: begin
            if (FRAME_B) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (!IRDY_B) begin
               state_d = ACK;
               if (cmd_q) begin
                  wr_en = 1'b1;
               end else begin
                  ad_out_d = mem_q[idx_q];
               end
            end
         end
         ACK: begin
            state_d = TURN;
         end
         TURN: begin
            if (FRAME_B) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control registers. Reset returns the target to IDLE, which releases
   // both bus outputs at once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         idx_q    <= '0;
         cmd_q    <= 1'b0;
         ad_out_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         cmd_q    <= cmd_d;
         ad_out_q <= ad_out_d;
      end
   end

   // Register file. Write data is taken from AD on the edge that asserts
   // TRDY_B. Reset clears every word, so an interrupted write never lands.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'd0;
         end
      end else if (wr_en) begin
         mem_q[idx_q] <= AD;
      end
   end

endmodule

// File: tb/tb_dsp_target.sv
// -----------------------------------------------------------------------------
// tb_dsp_target
//
// Directed testbench for dsp_target. Three targets share one pulled-up bus:
//   dutW1  BASE 0x100, WAIT_STATES 1
//   dutW0  BASE 0x400, WAIT_STATES 0
//   dutW3  BASE 0x500, WAIT_STATES 3
// Address 0x200 decodes to none of them.
// Inputs change 1 ns after each rising edge. Outputs are sampled at that
// same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_dsp_target;

   logic        CLK = 1'b0;
   logic        RST;
   logic        FRAME_B;
   logic        CMD;
   logic        IRDY_B;
   logic [31:0] tbAd;
   logic        tbAdOe;
   tri1         TRDY_B;
   tri1  [31:0] AD;

   int testsRun    = 0;
   int testsFailed = 0;

   assign AD = tbAdOe ? tbAd : 32'hz;

   // Free-running 100 MHz bus clock.
   always #5 CLK = ~CLK;

   dsp_target #(.BASE_ADDR(32'h0000_0100), .AW(4), .WAIT_STATES(1)) dutW1 (
      .CLK(CLK), .RST(RST), .FRAME_B(FRAME_B), .CMD(CMD),
      .IRDY_B(IRDY_B), .TRDY_B(TRDY_B), .AD(AD));

   dsp_target #(.BASE_ADDR(32'h0000_0400), .AW(4), .WAIT_STATES(0)) dutW0 (
      .CLK(CLK), .RST(RST), .FRAME_B(FRAME_B), .CMD(CMD),
      .IRDY_B(IRDY_B), .TRDY_B(TRDY_B), .AD(AD));

   dsp_target #(.BASE_ADDR(32'h0000_0500), .AW(4), .WAIT_STATES(3)) dutW3 (
      .CLK(CLK), .RST(RST), .FRAME_B(FRAME_B), .CMD(CMD),
      .IRDY_B(IRDY_B), .TRDY_B(TRDY_B), .AD(AD));

   // Compare one observed value against its expected value. Record any
   // failure and report it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
      end
   endtask

   task automatic nextEdge();
      @(posedge CLK);
      #1;
   endtask

   // Run one complete hit transaction. The task records the edge number
   // (E1 = address edge) on which TRDY_B is first seen low. IRDY_B is held
   // high for irdyDelay cycles after E1. FRAME_B can also be held low for
   // staleHold cycles after the ACK exit.
   task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                input logic isWrite, input logic [31:0] wdata,
                                input int irdyDelay, input int staleHold,
                                input int expAckEdge, input logic [31:0] expRdata);
      int          ackEdge;
      logic [31:0] rdata;
      ackEdge = 0;
      rdata   = 32'd0;
      FRAME_B = 1'b0;
      CMD     = isWrite;
      tbAd    = addr;
      tbAdOe  = 1'b1;
      IRDY_B  = 1'b1;
      nextEdge();
      tbAd   = wdata;
      tbAdOe = isWrite;
      for (int k = 2; k <= 40 && ackEdge == 0; k++) begin
         IRDY_B = (k - 2 < irdyDelay);
         nextEdge();
         if (TRDY_B === 1'b0) begin
            ackEdge = k;
            rdata   = AD;
         end
      end
      checkOutput({tag, " ack edge"}, 32'(ackEdge), 32'(expAckEdge));
      if (!isWrite) begin
         checkOutput({tag, " read data"}, rdata, expRdata);
      end
      nextEdge();
      checkOutput({tag, " trdy released"}, {31'd0, TRDY_B}, 32'h1);
      if (!isWrite) begin
         checkOutput({tag, " ad released"}, AD, 32'hFFFF_FFFF);
      end
      if (staleHold > 0) begin
         tbAd   = addr;
         tbAdOe = 1'b1;
         IRDY_B = 1'b0;
         for (int i = 0; i < staleHold; i++) begin
            nextEdge();
            checkOutput({tag, " stale frame ignored"}, {31'd0, TRDY_B}, 32'h1);
         end
      end
      FRAME_B = 1'b1;
      IRDY_B  = 1'b1;
      CMD     = 1'b0;
      tbAdOe  = 1'b0;
      nextEdge();
   endtask

   // Access an address that no target decodes. The test checks that TRDY_B
   // stays released on every cycle. For reads it also checks that AD stays
   // released.
   task automatic applyMiss(input string tag, input logic [31:0] addr,
                            input logic isWrite, input logic [31:0] wdata);
      FRAME_B = 1'b0;
      CMD     = isWrite;
      tbAd    = addr;
      tbAdOe  = 1'b1;
      IRDY_B  = 1'b1;
      nextEdge();
      tbAd   = wdata;
      tbAdOe = isWrite;
      IRDY_B = 1'b0;
      for (int i = 0; i < 5; i++) begin
         nextEdge();
         checkOutput({tag, " trdy released"}, {31'd0, TRDY_B}, 32'h1);
         if (!isWrite) begin
            checkOutput({tag, " ad released"}, AD, 32'hFFFF_FFFF);
         end
      end
      FRAME_B = 1'b1;
      IRDY_B  = 1'b1;
      CMD     = 1'b0;
      tbAdOe  = 1'b0;
      nextEdge();
   endtask

   // Safety net in case the directed sequence stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before the end of the sequence");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence.
   initial begin
      RST     = 1'b1;
      FRAME_B = 1'b1;
      CMD     = 1'b0;
      IRDY_B  = 1'b1;
      tbAd    = 32'd0;
      tbAdOe  = 1'b0;
      nextEdge();
      nextEdge();
      checkOutput("reset trdy", {31'd0, TRDY_B}, 32'h1);
      checkOutput("reset ad", AD, 32'hFFFF_FFFF);
      RST = 1'b0;
      nextEdge();

      // Write followed by read with one wait state.
      applyStimulus("w1 write 105", 32'h105, 1'b1, 32'hDEAD_BEEF, 0, 0, 3, 32'd0);
      applyStimulus("w1 read 105", 32'h105, 1'b0, 32'd0, 0, 0, 3, 32'hDEAD_BEEF);

      // Reads of untouched words with zero and three wait states.
      applyStimulus("w0 read 400", 32'h400, 1'b0, 32'd0, 0, 0, 2, 32'd0);
      applyStimulus("w3 read 500", 32'h500, 1'b0, 32'd0, 0, 0, 5, 32'd0);

      // Accesses to 0x200 decode to no target. The low bits of 0x200 alias
      // index 0 of every target, so 0x100 must remain zero.
      applyMiss("miss read 200", 32'h200, 1'b0, 32'd0);
      applyMiss("miss write 200", 32'h200, 1'b1, 32'h0BAD_F00D);
      applyStimulus("w1 read 100 after miss", 32'h100, 1'b0, 32'd0, 0, 0, 3, 32'd0);
      applyStimulus("w1 read 105 after miss", 32'h105, 1'b0, 32'd0, 0, 0, 3, 32'hDEAD_BEEF);

      // Late IRDY_B: held high for 4 cycles after E1, so the ACK moves to E6.
      applyStimulus("w1 late irdy write 10f", 32'h10F, 1'b1, 32'h1234_5678, 4, 0, 6, 32'd0);
      applyStimulus("w1 read 10f", 32'h10F, 1'b0, 32'd0, 0, 0, 3, 32'h1234_5678);

      // FRAME_B is released in DATA on the same edge that IRDY_B goes low.
      // The abort must win and nothing is written.
      FRAME_B = 1'b0;
      CMD     = 1'b1;
      tbAd    = 32'h103;
      tbAdOe  = 1'b1;
      IRDY_B  = 1'b1;
      nextEdge();
      tbAd = 32'hCAFE_F00D;
      nextEdge();
      FRAME_B = 1'b1;
      IRDY_B  = 1'b0;
      nextEdge();
      checkOutput("abort trdy released", {31'd0, TRDY_B}, 32'h1);
      IRDY_B = 1'b1;
      CMD    = 1'b0;
      tbAdOe = 1'b0;
      nextEdge();
      applyStimulus("w1 read 103 after abort", 32'h103, 1'b0, 32'd0, 0, 0, 3, 32'd0);

      // FRAME_B is held low for 3 cycles after the ACK exit. No second decode
      // may occur until FRAME_B has been seen high.
      applyStimulus("w0 stale frame read 400", 32'h400, 1'b0, 32'd0, 0, 3, 2, 32'd0);
      applyStimulus("w0 read 405 after stale", 32'h405, 1'b0, 32'd0, 0, 0, 2, 32'd0);

      // Reset is asserted in the middle of DATA, one edge before the write
      // would commit. Afterwards all storage reads back as zero.
      FRAME_B = 1'b0;
      CMD     = 1'b1;
      tbAd    = 32'h105;
      tbAdOe  = 1'b1;
      IRDY_B  = 1'b0;
      nextEdge();
      tbAd = 32'h1111_1111;
      nextEdge();
      #2;
      RST = 1'b1;
      #1;
      checkOutput("reset mid data trdy", {31'd0, TRDY_B}, 32'h1);
      FRAME_B = 1'b1;
      IRDY_B  = 1'b1;
      CMD     = 1'b0;
      tbAdOe  = 1'b0;
      nextEdge();
      RST = 1'b0;
      nextEdge();
      applyStimulus("w1 read 105 after reset", 32'h105, 1'b0, 32'd0, 0, 0, 3, 32'd0);
      applyStimulus("w1 read 10f after reset", 32'h10F, 1'b0, 32'd0, 0, 0, 3, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
